// File: rtl/elevator_pkg.sv
// Shared types and helpers for the elevator car controller.
package elevator_pkg;

   localparam int unsigned DEFAULT_NUM_FLOORS = 3;
   localparam int unsigned MAX_FLOORS         = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOVE_UP   = 2'd1,
      MOVE_DOWN = 2'd2,
      DOOR_OPEN = 2'd3
   } elev_state_t;

   // Callers zero-extend to MAX_FLOORS; cur must be one-hot.
   function automatic logic any_above(input logic [MAX_FLOORS-1:0] pend,
                                      input logic [MAX_FLOORS-1:0] cur);
      logic [MAX_FLOORS-1:0] mask;
      mask = ~((cur << 1) - MAX_FLOORS'(1));
      return |(pend & mask);
   endfunction

   function automatic logic any_below(input logic [MAX_FLOORS-1:0] pend,
                                      input logic [MAX_FLOORS-1:0] cur);
      logic [MAX_FLOORS-1:0] mask;
      mask = cur - MAX_FLOORS'(1);
      return |(pend & mask);
   endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter shared by travel and door dwell; done when it reaches zero.
module elevator_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         freeze_i,
   output logic         done_o
);

   logic [W-1:0] count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else if (load_i) begin
         count_q <= load_val_i;
      end else if (!freeze_i && (count_q != '0)) begin
         count_q <= count_q - W'(1);
      end
   end

   assign done_o = (count_q == '0);

endmodule

// File: rtl/elevator_controller.sv
// SCAN-scheduled elevator car sequencer with travel and door dwell timing.
// Optional emergency stop input enabled by defining ELEVATOR_ESTOP_EN.
module elevator_controller
   import elevator_pkg::*;
#(
   parameter int unsigned NUM_FLOORS    = DEFAULT_NUM_FLOORS,
   parameter int unsigned TRAVEL_CYCLES = 50_000_000,
   parameter int unsigned DOOR_CYCLES   = 100_000_000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] req,
`ifdef ELEVATOR_ESTOP_EN
   input  logic                  estop,
`endif
   output logic [NUM_FLOORS-1:0] floor_onehot,
   output logic                  door_open,
   output logic                  moving,
   output logic                  dir_up,
   output logic [NUM_FLOORS-1:0] pending
);

   localparam int unsigned MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
   localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [TMR_W-1:0] TRAVEL_LOAD = TMR_W'(TRAVEL_CYCLES - 1);
   localparam logic [TMR_W-1:0] DOOR_LOAD   = TMR_W'(DOOR_CYCLES - 1);

   elev_state_t           state_q, state_d;
   logic [NUM_FLOORS-1:0] floor_q, floor_d;
   logic [NUM_FLOORS-1:0] pending_q, pending_d;
   logic                  dir_q, dir_d;
   logic                  door_q, door_d;
   logic                  moving_q, moving_d;

   logic                  hold;
   logic                  tmr_load;
   logic [TMR_W-1:0]      tmr_val;
   logic                  tmr_done;
   logic [NUM_FLOORS-1:0] pend_req;
   logic [NUM_FLOORS-1:0] floor_up;
   logic [NUM_FLOORS-1:0] floor_dn;
   logic                  cur_req;

`ifdef ELEVATOR_ESTOP_EN
   assign hold = estop;
`else
   assign hold = 1'b0;
`endif

   assign pend_req = pending_q | req;
   assign cur_req  = |(req & floor_q);
   assign floor_up = floor_q[NUM_FLOORS-1] ? floor_q : {floor_q[NUM_FLOORS-2:0], 1'b0};
   assign floor_dn = floor_q[0] ? floor_q : {1'b0, floor_q[NUM_FLOORS-1:1]};

   elevator_timer #(.W(TMR_W)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .freeze_i   (hold),
      .done_o     (tmr_done)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: SCAN scheduling; arrival decisions use the floor being entered
   always_comb begin
      state_d = state_q;
      if (!hold) begin
         case (state_q)
            IDLE: begin
               if (|(pending_q & floor_q)) begin
                  state_d = DOOR_OPEN;
               end else if (dir_q && any_above(MAX_FLOORS'(pending_q), MAX_FLOORS'(floor_q))) begin
                  state_d = MOVE_UP;
               end else if (!dir_q && any_below(MAX_FLOORS'(pending_q), MAX_FLOORS'(floor_q))) begin
                  state_d = MOVE_DOWN;
               end else if (any_above(MAX_FLOORS'(pending_q), MAX_FLOORS'(floor_q))) begin
                  state_d = MOVE_UP;
               end else if (any_below(MAX_FLOORS'(pending_q), MAX_FLOORS'(floor_q))) begin
                  state_d = MOVE_DOWN;
               end
            end
            MOVE_UP: begin
               if (tmr_done) begin
                  if (|(pend_req & floor_up)) begin
                     state_d = DOOR_OPEN;
                  end else if (!any_above(MAX_FLOORS'(pend_req), MAX_FLOORS'(floor_up))) begin
                     state_d = IDLE;
                  end
               end
            end
            MOVE_DOWN: begin
               if (tmr_done) begin
                  if (|(pend_req & floor_dn)) begin
                     state_d = DOOR_OPEN;
                  end else if (!any_below(MAX_FLOORS'(pend_req), MAX_FLOORS'(floor_dn))) begin
                     state_d = IDLE;
                  end
               end
            end
            DOOR_OPEN: begin
               if (tmr_done && !cur_req) begin
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Datapath and output next values
   always_comb begin
      pending_d = pend_req;
      floor_d   = floor_q;
      dir_d     = dir_q;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      if (state_q == DOOR_OPEN) begin
         pending_d = pending_q | (req & ~floor_q);
      end
      if (!hold) begin
         if ((state_q == MOVE_UP) && tmr_done) begin
            floor_d = floor_up;
         end
         if ((state_q == MOVE_DOWN) && tmr_done) begin
            floor_d = floor_dn;
         end
         if ((state_q == DOOR_OPEN) && cur_req) begin
            tmr_load = 1'b1;
            tmr_val  = DOOR_LOAD;
         end
         if ((state_d != state_q) ||
             (((state_q == MOVE_UP) || (state_q == MOVE_DOWN)) && tmr_done)) begin
            tmr_load = 1'b1;
            case (state_d)
               MOVE_UP, MOVE_DOWN: tmr_val = TRAVEL_LOAD;
               DOOR_OPEN:          tmr_val = DOOR_LOAD;
               default:            tmr_val = '0;
            endcase
         end
         if ((state_d == DOOR_OPEN) && (state_q != DOOR_OPEN)) begin
            pending_d = pending_d & ~floor_d;
         end
         if (state_d == MOVE_UP) begin
            dir_d = 1'b1;
         end else if (state_d == MOVE_DOWN) begin
            dir_d = 1'b0;
         end
      end
      door_d   = (state_d == DOOR_OPEN);
      moving_d = ((state_d == MOVE_UP) || (state_d == MOVE_DOWN)) && !hold;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         floor_q   <= NUM_FLOORS'(1);
         pending_q <= '0;
         dir_q     <= 1'b1;
         door_q    <= 1'b0;
         moving_q  <= 1'b0;
      end else begin
         floor_q   <= floor_d;
         pending_q <= pending_d;
         dir_q     <= dir_d;
         door_q    <= door_d;
         moving_q  <= moving_d;
      end
   end

   assign floor_onehot = floor_q;
   assign pending      = pending_q;
   assign dir_up       = dir_q;
   assign door_open    = door_q;
   assign moving       = moving_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Directed self-checking bench for elevator_controller (TRAVEL_CYCLES=4, DOOR_CYCLES=3).
`timescale 1ns/1ps
module tb_elevator_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] req = 3'b000;
`ifdef ELEVATOR_ESTOP_EN
   logic       estop = 1'b0;
`endif
   logic [2:0] floor_onehot;
   logic       door_open;
   logic       moving;
   logic       dir_up;
   logic [2:0] pending;

   int checks   = 0;
   int failures = 0;

   elevator_controller #(
      .NUM_FLOORS    (3),
      .TRAVEL_CYCLES (4),
      .DOOR_CYCLES   (3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
`ifdef ELEVATOR_ESTOP_EN
      .estop        (estop),
`endif
      .floor_onehot (floor_onehot),
      .door_open    (door_open),
      .moving       (moving),
      .dir_up       (dir_up),
      .pending      (pending)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 3'b000;
      tick(2);
      rst = 1'b0;
      checks++; if (floor_onehot !== 3'b001) begin failures++; $display("FAIL reset_floor got=%b exp=001", floor_onehot); end
      checks++; if (pending !== 3'b000) begin failures++; $display("FAIL reset_pending got=%b exp=000", pending); end
      checks++; if (door_open !== 1'b0) begin failures++; $display("FAIL reset_door got=%b exp=0", door_open); end
      checks++; if (moving !== 1'b0) begin failures++; $display("FAIL reset_moving got=%b exp=0", moving); end
      checks++; if (dir_up !== 1'b1) begin failures++; $display("FAIL reset_dir got=%b exp=1", dir_up); end
   endtask

   // Floor 1 -> floor 3 with no intermediate stop
   task automatic test_travel_up();
      req = 3'b100; tick(1); req = 3'b000;
      checks++; if (pending !== 3'b100) begin failures++; $display("FAIL up_pending_latch got=%b exp=100", pending); end
      checks++; if (moving !== 1'b0) begin failures++; $display("FAIL up_idle_before_move got=%b exp=0", moving); end
      tick(1);
      checks++; if (moving !== 1'b1) begin failures++; $display("FAIL up_move_start got=%b exp=1", moving); end
      tick(3);
      checks++; if (floor_onehot !== 3'b001) begin failures++; $display("FAIL up_floor_before_step got=%b exp=001", floor_onehot); end
      tick(1);
      checks++; if (floor_onehot !== 3'b010) begin failures++; $display("FAIL up_floor2 got=%b exp=010", floor_onehot); end
      checks++; if (moving !== 1'b1) begin failures++; $display("FAIL up_pass_floor2 got=%b exp=1", moving); end
      tick(4);
      checks++; if (floor_onehot !== 3'b100) begin failures++; $display("FAIL up_floor3 got=%b exp=100", floor_onehot); end
      checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL up_door_open got=%b exp=1", door_open); end
      checks++; if (pending !== 3'b000) begin failures++; $display("FAIL up_pending_clear got=%b exp=000", pending); end
      checks++; if (moving !== 1'b0) begin failures++; $display("FAIL up_stopped got=%b exp=0", moving); end
      tick(2);
      checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL up_door_dwell got=%b exp=1", door_open); end
      tick(1);
      checks++; if (door_open !== 1'b0) begin failures++; $display("FAIL up_door_close got=%b exp=0", door_open); end
      checks++; if (dir_up !== 1'b1) begin failures++; $display("FAIL up_dir got=%b exp=1", dir_up); end
   endtask

   // Floor 3 (dir_up=1) -> floor 1, reversing and passing floor 2
   task automatic test_travel_down();
      req = 3'b001; tick(1); req = 3'b000;
      tick(1);
      checks++; if (moving !== 1'b1) begin failures++; $display("FAIL dn_move_start got=%b exp=1", moving); end
      checks++; if (dir_up !== 1'b0) begin failures++; $display("FAIL dn_dir got=%b exp=0", dir_up); end
      tick(4);
      checks++; if (floor_onehot !== 3'b010) begin failures++; $display("FAIL dn_floor2 got=%b exp=010", floor_onehot); end
      checks++; if (door_open !== 1'b0) begin failures++; $display("FAIL dn_no_stop_floor2 got=%b exp=0", door_open); end
      tick(4);
      checks++; if (floor_onehot !== 3'b001) begin failures++; $display("FAIL dn_floor1 got=%b exp=001", floor_onehot); end
      checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL dn_door_open got=%b exp=1", door_open); end
      checks++; if (pending !== 3'b000) begin failures++; $display("FAIL dn_pending_clear got=%b exp=000", pending); end
      tick(3);
      checks++; if (door_open !== 1'b0) begin failures++; $display("FAIL dn_door_close got=%b exp=0", door_open); end
   endtask

   // Call at the current floor, held through the door to extend dwell
   task automatic test_same_floor();
      logic saw_move;
      saw_move = 1'b0;
      req = 3'b001; tick(1);
      checks++; if (pending !== 3'b001) begin failures++; $display("FAIL sf_pending_latch got=%b exp=001", pending); end
      tick(1);
      checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL sf_door_open got=%b exp=1", door_open); end
      checks++; if (pending !== 3'b000) begin failures++; $display("FAIL sf_pending_clear got=%b exp=000", pending); end
      for (int i = 0; i < 4; i++) begin
         tick(1);
         saw_move |= moving;
         checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL sf_door_hold[%0d] got=%b exp=1", i, door_open); end
         checks++; if (pending !== 3'b000) begin failures++; $display("FAIL sf_no_latch[%0d] got=%b exp=000", i, pending); end
      end
      req = 3'b000;
      tick(2);
      saw_move |= moving;
      checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL sf_door_after_release got=%b exp=1", door_open); end
      tick(1);
      checks++; if (door_open !== 1'b0) begin failures++; $display("FAIL sf_door_close got=%b exp=0", door_open); end
      tick(2);
      saw_move |= moving;
      checks++; if (door_open !== 1'b0) begin failures++; $display("FAIL sf_no_reopen got=%b exp=0", door_open); end
      checks++; if (saw_move !== 1'b0) begin failures++; $display("FAIL sf_never_moved got=%b exp=0", saw_move); end
   endtask

   // Car heading to floor 3 picks up a call arriving on the floor-2 arrival edge
   task automatic test_intermediate_stop();
      req = 3'b100; tick(1); req = 3'b000;
      tick(1);
      checks++; if (dir_up !== 1'b1) begin failures++; $display("FAIL is_dir got=%b exp=1", dir_up); end
      tick(3);
      req = 3'b010; tick(1); req = 3'b000;
      checks++; if (floor_onehot !== 3'b010) begin failures++; $display("FAIL is_floor2 got=%b exp=010", floor_onehot); end
      checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL is_door_floor2 got=%b exp=1", door_open); end
      checks++; if (pending !== 3'b100) begin failures++; $display("FAIL is_pending_keep got=%b exp=100", pending); end
      tick(3);
      checks++; if (door_open !== 1'b0) begin failures++; $display("FAIL is_door_close got=%b exp=0", door_open); end
      tick(1);
      checks++; if (moving !== 1'b1) begin failures++; $display("FAIL is_resume got=%b exp=1", moving); end
      tick(4);
      checks++; if (floor_onehot !== 3'b100) begin failures++; $display("FAIL is_floor3 got=%b exp=100", floor_onehot); end
      checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL is_door_floor3 got=%b exp=1", door_open); end
      tick(3);
   endtask

   // Reset between floors 3 and 2 while travelling down
   task automatic test_reset_mid_travel();
      req = 3'b001; tick(1); req = 3'b000;
      tick(3);
      checks++; if (moving !== 1'b1) begin failures++; $display("FAIL rm_moving_before got=%b exp=1", moving); end
      rst = 1'b1; tick(1);
      checks++; if (floor_onehot !== 3'b001) begin failures++; $display("FAIL rm_floor got=%b exp=001", floor_onehot); end
      checks++; if (pending !== 3'b000) begin failures++; $display("FAIL rm_pending got=%b exp=000", pending); end
      checks++; if (moving !== 1'b0) begin failures++; $display("FAIL rm_moving got=%b exp=0", moving); end
      checks++; if (dir_up !== 1'b1) begin failures++; $display("FAIL rm_dir got=%b exp=1", dir_up); end
      rst = 1'b0; tick(6);
      checks++; if (moving !== 1'b0) begin failures++; $display("FAIL rm_stays_idle got=%b exp=0", moving); end
      checks++; if (floor_onehot !== 3'b001) begin failures++; $display("FAIL rm_floor_after got=%b exp=001", floor_onehot); end
   endtask

`ifdef ELEVATOR_ESTOP_EN
   // Five-cycle freeze mid-travel delays arrival by five edges
   task automatic test_estop();
      req = 3'b010; tick(1); req = 3'b000;
      tick(3);
      estop = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         checks++; if (moving !== 1'b0) begin failures++; $display("FAIL es_moving[%0d] got=%b exp=0", i, moving); end
         checks++; if (floor_onehot !== 3'b001) begin failures++; $display("FAIL es_floor[%0d] got=%b exp=001", i, floor_onehot); end
      end
      estop = 1'b0;
      tick(1);
      checks++; if (moving !== 1'b1) begin failures++; $display("FAIL es_resume got=%b exp=1", moving); end
      checks++; if (floor_onehot !== 3'b001) begin failures++; $display("FAIL es_not_yet got=%b exp=001", floor_onehot); end
      tick(1);
      checks++; if (floor_onehot !== 3'b010) begin failures++; $display("FAIL es_arrive got=%b exp=010", floor_onehot); end
      checks++; if (door_open !== 1'b1) begin failures++; $display("FAIL es_door got=%b exp=1", door_open); end
      tick(3);
   endtask
`endif

   initial begin
      test_reset();
      test_travel_up();
      test_travel_down();
      test_same_floor();
      test_intermediate_stop();
      test_reset_mid_travel();
`ifdef ELEVATOR_ESTOP_EN
      test_estop();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
